is_launch_ctrl: RTL and testbench
=================================

// Module: is_launch_ctrl
// PURPOSE
//  Consumer side of the issue FIFO in the dual-issue pipeline. Inspects the decoded head pair presented by the FIFO.
//  Decides each cycle to launch 0, 1 or 2 instructions into the next stage.
//  Drives the one-hot launch flags that advance the FIFO read pointer.
//  Holds the long-latency register scoreboard and the serialising-instruction FSM.
// PARAMETERS
//  NUM_GPR        32  architectural registers; r0 is never busy
//  DOUBLE_LAUNCH  1   0 = lane2 never launches
//  STALL_CNT_WD   32  width of the stall-cycle counter (saturating)
// PORTS
//  clk                 in   1   single clock, rising edge
//  reset               in   1   synchronous, active-high
//  flush_i             in   1   pipeline flush from hazard unit
//  line1_valid_i       in   1   FIFO head entry valid
//  line2_valid_i       in   1   FIFO head+1 entry valid
//  line1_info_i        in   24  {rj,rk,rd[5 each], use_rj,use_rk,we,is_mem,is_muldiv,long_lat,is_br,serial,rsv}
//  line2_info_i        in   24  same layout as line1_info_i
//  next_allowin_i      in   1   next stage can accept this cycle
//  backend_idle_i      in   1   no instruction in flight past the issue stage
//  wb1_valid_i/wb2_valid_i  in  1  long-latency writeback ports
//  wb1_rd_i/wb2_rd_i   in   5   register released by each writeback port
//  double_valid_inst_lunch_flag_o  out 1  two entries launched
//  single_valid_inst_lunch_flag_o  out 1  line1 only launched
//  zero_valid_inst_lunch_flag_o    out 1  nothing launched
//  line1_issue_o/line2_issue_o     out 1  per-lane valid into next stage
//  stall_cnt_o         out  STALL_CNT_WD  cycles with line1_valid_i=1 and no launch
// BEHAVIOUR
//  - Outputs are combinational from state and inputs; zero latency. The FIFO consumes on the same edge.
//  - Exactly one launch flag is high each cycle. line2_issue_o implies line1_issue_o.
//  - Reset values: all flags 0 except zero flag 1; busy[] all 0; state IDLE; stall_cnt_o 0.
//  - flush_i: no launch that cycle. busy[] cleared, state to IDLE on the next edge. stall_cnt_o is held.
//  - lane1 launches iff: line1_valid_i, next_allowin_i, no scoreboard hazard, and FSM permits.
//    Scoreboard hazard = used rj/rk busy, or (we and rd busy).
//  - lane2 additionally requires all of:
//    DOUBLE_LAUNCH=1; line2_valid_i; lane2 scoreboard clear; line1 neither serial nor is_br; line2 not serial.
//    No structural conflict: not both is_mem, not both is_muldiv.
//    No RAW or WAW against line1.rd when line1.we and line1.rd!=0.
//  - Scoreboard: busy[rd] is set on the edge after launch of a lane with we & long_lat & rd!=0.
//    busy[rd] is cleared on the edge after wb*_valid_i.
//    Set and clear of the same rd in one cycle: set wins.
//    Two lanes may set two registers in one cycle. Writeback to a non-busy register has no effect.
//  - FSM IDLE/DRAIN/SOLO:
//    IDLE: line1 serial & valid -> DRAIN, no launch.
//    DRAIN: no launch; busy[]==0 & backend_idle_i -> SOLO.
//    SOLO: single launch of line1 when next_allowin_i, then -> IDLE; hold while !next_allowin_i.
//    Flush from any state -> IDLE.
//  - stall_cnt_o increments when line1_valid_i & zero flag & !flush_i. Saturates at all-ones; no wrap.
//  - With line1_valid_i=0, line2 is ignored: zero launch.
// STRUCTURE
//  - Shared define header: info-field bit offsets, LINE_INFO_WD=24, FSM state codes (2-bit), NUM_GPR.
//  - Sub-module is_scoreboard:
//    busy vector, 2 set ports, 2 clear ports, flush.
//    4 source-check read ports, 2 dest-check read ports; all_clear output.
//  - Top: pairing logic, FSM, stall counter.
// TESTING
//  1. Independent add pair (r1<-r2, r3<-r4), allowin=1 -> double flag, both issue bits 1.
//  2. line1 r5<-.., line2 reads r5 -> single flag; next cycle new head line1 reads r5 -> launches (short latency).
//  3. line1 ld r6 (long_lat) launched; next head reads r6 -> zero flag, stall_cnt +1 per cycle.
//     wb1 r6 -> launch the following cycle.
//  4. Serial CSR at head with busy[7]=1:
//     DRAIN until wb r7 & backend_idle_i=1, then single launch, then IDLE; never paired.
//  5. wb1_rd=8 and launch of new long-latency r8 writer in the same cycle -> busy[8] stays 1.
//  6. Flush during DRAIN with busy[9]=1 -> next cycle IDLE, busy all 0, zero flag in flush cycle.

Source files
------------

// File: rtl/is_launch_ctrl_pkg.sv
// Shared definitions for the issue-stage launch controller: info-field layout,
// FSM state codes and the decoded per-lane view of a FIFO entry.
package is_launch_ctrl_pkg;

  localparam int unsigned LINE_INFO_WD = 24;
  localparam int unsigned REG_ADDR_WD  = 5;
  localparam int unsigned NUM_GPR_ARCH = 32;

  // Bit positions inside line*_info_i, MSB first.
  localparam int unsigned INFO_RJ_LSB    = 19;
  localparam int unsigned INFO_RK_LSB    = 14;
  localparam int unsigned INFO_RD_LSB    = 9;
  localparam int unsigned INFO_USE_RJ    = 8;
  localparam int unsigned INFO_USE_RK    = 7;
  localparam int unsigned INFO_WE        = 6;
  localparam int unsigned INFO_IS_MEM    = 5;
  localparam int unsigned INFO_IS_MULDIV = 4;
  localparam int unsigned INFO_LONG_LAT  = 3;
  localparam int unsigned INFO_IS_BR     = 2;
  localparam int unsigned INFO_SERIAL    = 1;
  localparam int unsigned INFO_RSV       = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StDrain = 2'b01,
    StSolo  = 2'b10
  } issue_state_e;

  typedef struct packed {
    logic [REG_ADDR_WD-1:0] rj;
    logic [REG_ADDR_WD-1:0] rk;
    logic [REG_ADDR_WD-1:0] rd;
    logic                   use_rj;
    logic                   use_rk;
    logic                   we;
    logic                   is_mem;
    logic                   is_muldiv;
    logic                   long_lat;
    logic                   is_br;
    logic                   serial;
    logic                   rsv;
  } line_info_t;

  function automatic line_info_t decode_info(input logic [LINE_INFO_WD-1:0] info);
    line_info_t d;
    d.rj        = info[INFO_RJ_LSB +: REG_ADDR_WD];
    d.rk        = info[INFO_RK_LSB +: REG_ADDR_WD];
    d.rd        = info[INFO_RD_LSB +: REG_ADDR_WD];
    d.use_rj    = info[INFO_USE_RJ];
    d.use_rk    = info[INFO_USE_RK];
    d.we        = info[INFO_WE];
    d.is_mem    = info[INFO_IS_MEM];
    d.is_muldiv = info[INFO_IS_MULDIV];
    d.long_lat  = info[INFO_LONG_LAT];
    d.is_br     = info[INFO_IS_BR];
    d.serial    = info[INFO_SERIAL];
    d.rsv       = info[INFO_RSV];
    return d;
  endfunction

endpackage

// File: rtl/is_scoreboard.sv
// Long-latency register scoreboard: one busy bit per GPR, two set and two
// clear ports, plus combinational lookups for source and destination checks.
module is_scoreboard
  import is_launch_ctrl_pkg::*;
#(
  parameter int unsigned NUM_GPR = NUM_GPR_ARCH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [1:0]                  set_valid,
  input  logic [1:0][REG_ADDR_WD-1:0] set_addr,
  input  logic [1:0]                  clr_valid,
  input  logic [1:0][REG_ADDR_WD-1:0] clr_addr,
  input  logic [3:0][REG_ADDR_WD-1:0] src_addr,
  output logic [3:0]                  src_busy,
  input  logic [1:0][REG_ADDR_WD-1:0] dst_addr,
  output logic [1:0]                  dst_busy,
  output logic                        all_clear
);

  logic [NUM_GPR-1:0] busy_q;
  logic [NUM_GPR-1:0] busy_d;

  // Clears are applied first so a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < 2; i++) begin
      if (clr_valid[i]) begin
        busy_d[clr_addr[i]] = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (set_valid[i] && (set_addr[i] != '0)) begin
        busy_d[set_addr[i]] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
    if (flush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    src_busy = '0;
    dst_busy = '0;
    for (int i = 0; i < 4; i++) begin
      src_busy[i] = busy_q[src_addr[i]];
    end
    for (int i = 0; i < 2; i++) begin
      dst_busy[i] = busy_q[dst_addr[i]];
    end
  end

  assign all_clear = (busy_q == '0);

endmodule

// File: rtl/is_launch_ctrl.sv
// Issue-FIFO consumer: decides 0/1/2 launches per cycle from the head pair,
// tracks long-latency writers and serialises CSR-style instructions.
module is_launch_ctrl
  import is_launch_ctrl_pkg::*;
#(
  parameter int unsigned NUM_GPR       = NUM_GPR_ARCH,
  parameter bit          DOUBLE_LAUNCH = 1'b1,
  parameter int unsigned STALL_CNT_WD  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    line1_valid_i,
  input  logic                    line2_valid_i,
  input  logic [LINE_INFO_WD-1:0] line1_info_i,
  input  logic [LINE_INFO_WD-1:0] line2_info_i,
  input  logic                    next_allowin_i,
  input  logic                    backend_idle_i,
  input  logic                    wb1_valid_i,
  input  logic                    wb2_valid_i,
  input  logic [REG_ADDR_WD-1:0]  wb1_rd_i,
  input  logic [REG_ADDR_WD-1:0]  wb2_rd_i,
  output logic                    double_valid_inst_lunch_flag_o,
  output logic                    single_valid_inst_lunch_flag_o,
  output logic                    zero_valid_inst_lunch_flag_o,
  output logic                    line1_issue_o,
  output logic                    line2_issue_o,
  output logic [STALL_CNT_WD-1:0] stall_cnt_o
);

  line_info_t l1;
  line_info_t l2;

  assign l1 = decode_info(line1_info_i);
  assign l2 = decode_info(line2_info_i);

  // Lane2 branches may pair; reserved bits carry nothing.
  logic unused_info;
  assign unused_info = ^{l1.rsv, l2.rsv, l2.is_br};

  logic [3:0] src_busy;
  logic [1:0] dst_busy;
  logic       all_clear;
  logic [1:0] sb_set_valid;
  logic       l1_go;
  logic       l2_go;

  assign sb_set_valid[0] = l1_go && l1.we && l1.long_lat && (l1.rd != '0);
  assign sb_set_valid[1] = l2_go && l2.we && l2.long_lat && (l2.rd != '0);

  is_scoreboard #(
    .NUM_GPR (NUM_GPR)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_i),
    .set_valid (sb_set_valid),
    .set_addr  ({l2.rd, l1.rd}),
    .clr_valid ({wb2_valid_i, wb1_valid_i}),
    .clr_addr  ({wb2_rd_i, wb1_rd_i}),
    .src_addr  ({l2.rk, l2.rj, l1.rk, l1.rj}),
    .src_busy  (src_busy),
    .dst_addr  ({l2.rd, l1.rd}),
    .dst_busy  (dst_busy),
    .all_clear (all_clear)
  );

  logic hazard1;
  logic hazard2;
  logic dep_on_l1;
  logic struct_conflict;
  logic pair_ok;

  assign hazard1 = (l1.use_rj && src_busy[0]) || (l1.use_rk && src_busy[1]) ||
                   (l1.we && dst_busy[0]);
  assign hazard2 = (l2.use_rj && src_busy[2]) || (l2.use_rk && src_busy[3]) ||
                   (l2.we && dst_busy[1]);

  // RAW/WAW within the pair; r0 writes never create a dependency.
  assign dep_on_l1 = l1.we && (l1.rd != '0) &&
                     ((l2.use_rj && (l2.rj == l1.rd)) ||
                      (l2.use_rk && (l2.rk == l1.rd)) ||
                      (l2.we && (l2.rd == l1.rd)));

  assign struct_conflict = (l1.is_mem && l2.is_mem) || (l1.is_muldiv && l2.is_muldiv);

  assign pair_ok = DOUBLE_LAUNCH && line2_valid_i && !hazard2 && !l1.serial && !l1.is_br &&
                   !l2.serial && !struct_conflict && !dep_on_l1;

  issue_state_e state_q;
  issue_state_e state_d;

  always_comb begin
    state_d = state_q;
    l1_go   = 1'b0;
    l2_go   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (line1_valid_i) begin
          if (l1.serial) begin
            state_d = StDrain;
          end else if (next_allowin_i && !hazard1) begin
            l1_go = 1'b1;
            l2_go = pair_ok;
          end
        end
      end
      StDrain: begin
        if (all_clear && backend_idle_i) begin
          state_d = StSolo;
        end
      end
      StSolo: begin
        if (line1_valid_i && next_allowin_i && !hazard1) begin
          l1_go   = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (flush_i) begin
      state_d = StIdle;
      l1_go   = 1'b0;
      l2_go   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  logic [STALL_CNT_WD-1:0] stall_cnt_q;
  logic [STALL_CNT_WD-1:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (line1_valid_i && !l1_go && !flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign line1_issue_o                  = l1_go;
  assign line2_issue_o                  = l1_go && l2_go;
  assign double_valid_inst_lunch_flag_o = l1_go && l2_go;
  assign single_valid_inst_lunch_flag_o = l1_go && !l2_go;
  assign zero_valid_inst_lunch_flag_o   = !l1_go;
  assign stall_cnt_o                    = stall_cnt_q;

endmodule

// File: tb/tb_is_launch_ctrl.sv
// Directed bench for is_launch_ctrl: pairing, scoreboard stalls, serial drain
// and flush, with hand-computed flag and stall-count expectations.
module tb_is_launch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        line1_valid_i;
  logic        line2_valid_i;
  logic [23:0] line1_info_i;
  logic [23:0] line2_info_i;
  logic        next_allowin_i;
  logic        backend_idle_i;
  logic        wb1_valid_i;
  logic        wb2_valid_i;
  logic [4:0]  wb1_rd_i;
  logic [4:0]  wb2_rd_i;
  logic        dbl;
  logic        sgl;
  logic        zro;
  logic        l1_iss;
  logic        l2_iss;
  logic [31:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // {use_rj,use_rk,we,is_mem,is_muldiv,long_lat,is_br,serial}
  localparam logic [7:0] F_URJ = 8'h80;
  localparam logic [7:0] F_URK = 8'h40;
  localparam logic [7:0] F_WE  = 8'h20;
  localparam logic [7:0] F_MEM = 8'h10;
  localparam logic [7:0] F_LL  = 8'h04;
  localparam logic [7:0] F_BR  = 8'h02;
  localparam logic [7:0] F_SER = 8'h01;

  // {double,single,zero,line1_issue,line2_issue}
  localparam logic [4:0] EXP_DBL  = 5'b10011;
  localparam logic [4:0] EXP_SGL  = 5'b01010;
  localparam logic [4:0] EXP_ZERO = 5'b00100;

  is_launch_ctrl u_dut (
    .clk                            (clk),
    .reset                          (reset),
    .flush_i                        (flush_i),
    .line1_valid_i                  (line1_valid_i),
    .line2_valid_i                  (line2_valid_i),
    .line1_info_i                   (line1_info_i),
    .line2_info_i                   (line2_info_i),
    .next_allowin_i                 (next_allowin_i),
    .backend_idle_i                 (backend_idle_i),
    .wb1_valid_i                    (wb1_valid_i),
    .wb2_valid_i                    (wb2_valid_i),
    .wb1_rd_i                       (wb1_rd_i),
    .wb2_rd_i                       (wb2_rd_i),
    .double_valid_inst_lunch_flag_o (dbl),
    .single_valid_inst_lunch_flag_o (sgl),
    .zero_valid_inst_lunch_flag_o   (zro),
    .line1_issue_o                  (l1_iss),
    .line2_issue_o                  (l2_iss),
    .stall_cnt_o                    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic [4:0] rj, input logic [4:0] rk,
                                     input logic [4:0] rd, input logic [7:0] f);
    return {rj, rk, rd, f, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [4:0] exp);
    #1;
    chk(tag, {27'd0, dbl, sgl, zro, l1_iss, l2_iss}, {27'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    flush_i        = 1'b0;
    line1_valid_i  = 1'b0;
    line2_valid_i  = 1'b0;
    line1_info_i   = '0;
    line2_info_i   = '0;
    next_allowin_i = 1'b1;
    backend_idle_i = 1'b1;
    wb1_valid_i    = 1'b0;
    wb2_valid_i    = 1'b0;
    wb1_rd_i       = '0;
    wb2_rd_i       = '0;
    step();
    step();
    reset = 1'b0;
    chk_flags("reset_flags", EXP_ZERO);
    chk("reset_stall", stall_cnt, 32'd0);

    // Line2 alone is ignored.
    line2_valid_i = 1'b1;
    line2_info_i  = mk(5'd2, 5'd0, 5'd3, F_URJ | F_WE);
    chk_flags("l2_only", EXP_ZERO);
    step();

    // Independent pair.
    line1_valid_i = 1'b1;
    line1_info_i  = mk(5'd2, 5'd0, 5'd1, F_URJ | F_WE);
    line2_info_i  = mk(5'd4, 5'd0, 5'd3, F_URJ | F_WE);
    chk_flags("indep_pair", EXP_DBL);
    step();

    // RAW on r5 inside the pair.
    line1_info_i = mk(5'd2, 5'd0, 5'd5, F_URJ | F_WE);
    line2_info_i = mk(5'd5, 5'd0, 5'd10, F_URJ | F_WE);
    chk_flags("raw_pair", EXP_SGL);
    step();
    line2_valid_i = 1'b0;
    line1_info_i  = mk(5'd5, 5'd0, 5'd11, F_URJ | F_WE);
    chk_flags("raw_next_head", EXP_SGL);
    step();

    // Structural and branch restrictions.
    line2_valid_i = 1'b1;
    line1_info_i  = mk(5'd2, 5'd0, 5'd14, F_URJ | F_WE | F_MEM);
    line2_info_i  = mk(5'd3, 5'd0, 5'd15, F_URJ | F_WE | F_MEM);
    chk_flags("mem_mem", EXP_SGL);
    step();
    line1_info_i = mk(5'd2, 5'd3, 5'd0, F_URJ | F_URK | F_BR);
    line2_info_i = mk(5'd4, 5'd0, 5'd16, F_URJ | F_WE);
    chk_flags("br_lane1", EXP_SGL);
    step();

    // Long-latency load on r6 then a dependent consumer.
    line2_valid_i = 1'b0;
    line1_info_i  = mk(5'd1, 5'd0, 5'd6, F_URJ | F_WE | F_MEM | F_LL);
    chk_flags("ld_r6", EXP_SGL);
    step();
    line1_info_i = mk(5'd6, 5'd0, 5'd12, F_URJ | F_WE);
    chk_flags("use_r6_a", EXP_ZERO);
    chk("stall_0", stall_cnt, 32'd0);
    step();
    chk_flags("use_r6_b", EXP_ZERO);
    chk("stall_1", stall_cnt, 32'd1);
    step();
    wb1_valid_i = 1'b1;
    wb1_rd_i    = 5'd6;
    chk_flags("use_r6_wb", EXP_ZERO);
    chk("stall_2", stall_cnt, 32'd2);
    step();
    wb1_valid_i = 1'b0;
    chk_flags("use_r6_go", EXP_SGL);
    chk("stall_3", stall_cnt, 32'd3);
    step();

    // Serial instruction behind a long-latency r7 writer.
    line1_info_i = mk(5'd1, 5'd0, 5'd7, F_URJ | F_WE | F_LL);
    chk_flags("ld_r7", EXP_SGL);
    step();
    line2_valid_i = 1'b1;
    line1_info_i  = mk(5'd0, 5'd0, 5'd13, F_WE | F_SER);
    line2_info_i  = mk(5'd2, 5'd0, 5'd17, F_URJ | F_WE);
    chk_flags("ser_enter", EXP_ZERO);
    step();
    chk_flags("ser_drain_busy", EXP_ZERO);
    step();
    wb2_valid_i = 1'b1;
    wb2_rd_i    = 5'd7;
    chk_flags("ser_drain_wb", EXP_ZERO);
    step();
    wb2_valid_i    = 1'b0;
    backend_idle_i = 1'b0;
    chk_flags("ser_drain_bk", EXP_ZERO);
    step();
    backend_idle_i = 1'b1;
    chk_flags("ser_drain_exit", EXP_ZERO);
    step();
    next_allowin_i = 1'b0;
    chk_flags("ser_solo_hold", EXP_ZERO);
    step();
    next_allowin_i = 1'b1;
    chk_flags("ser_solo_go", EXP_SGL);
    step();
    line1_info_i = mk(5'd2, 5'd0, 5'd18, F_URJ | F_WE);
    line2_info_i = mk(5'd3, 5'd0, 5'd19, F_URJ | F_WE);
    chk_flags("ser_back_idle", EXP_DBL);
    chk("stall_9", stall_cnt, 32'd9);
    step();

    // Writeback and new long-latency writer of r8 in the same cycle.
    line2_valid_i = 1'b0;
    line1_info_i  = mk(5'd1, 5'd0, 5'd8, F_URJ | F_WE | F_LL);
    wb1_valid_i   = 1'b1;
    wb1_rd_i      = 5'd8;
    chk_flags("set_clr_r8", EXP_SGL);
    step();
    wb1_valid_i  = 1'b0;
    line1_info_i = mk(5'd0, 5'd8, 5'd20, F_URK | F_WE);
    chk_flags("r8_still_busy", EXP_ZERO);
    step();
    wb1_valid_i = 1'b1;
    chk_flags("r8_wb", EXP_ZERO);
    step();
    wb1_valid_i = 1'b0;
    chk_flags("r8_go", EXP_SGL);
    chk("stall_11", stall_cnt, 32'd11);
    step();

    // Flush while draining with r9 busy.
    line1_info_i = mk(5'd1, 5'd0, 5'd9, F_URJ | F_WE | F_LL);
    chk_flags("ld_r9", EXP_SGL);
    step();
    line1_info_i = mk(5'd0, 5'd0, 5'd0, F_SER);
    chk_flags("ser2_enter", EXP_ZERO);
    step();
    flush_i = 1'b1;
    chk_flags("flush_cycle", EXP_ZERO);
    step();
    flush_i      = 1'b0;
    line1_info_i = mk(5'd9, 5'd0, 5'd21, F_URJ | F_WE);
    chk_flags("post_flush_go", EXP_SGL);
    chk("stall_held", stall_cnt, 32'd12);
    step();

    line1_valid_i = 1'b0;
    chk_flags("idle_end", EXP_ZERO);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
